mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, word address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, number of backing words.
REQ-004 SHALL have parameter LATENCY, default 2, wait cycles before response; legal range 1..15.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port mem_valid_i  input  1  request valid from initiator, held until mem_ready_o.
REQ-008 SHALL have port mem_ready_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port mem_we_i  input  1  1=write, 0=read.
REQ-010 SHALL have port mem_adr_i  input  ADDR_WIDTH  word address.
REQ-011 SHALL have port mem_wdata_i  input  DATA_WIDTH  write data.
REQ-012 SHALL have port mem_rdata_o  output  DATA_WIDTH  read data, valid in mem_ready_o cycle.
REQ-013 SHALL have port err_o  output  1  address-error flag, qualified by mem_ready_o.

Function
REQ-014 SHALL store data in one prim_ram instance (depth MEM_DEPTH, 1-cycle registered read), addressed mem_adr_i[$clog2(MEM_DEPTH)-1:0].
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP, GAP.
REQ-016 IDLE: on mem_valid_i=1, latch we/adr/wdata, load wait counter with LATENCY-1, go WAIT.
REQ-017 WAIT: decrement counter each cycle; at counter 0 issue RAM read for reads (en=1, we=0), go RESP.
REQ-018 RESP: mem_ready_o=1 for exactly one cycle; reads drive mem_rdata_o from RAM output; writes commit RAM write this cycle; go GAP.
REQ-019 GAP: one cycle, mem_valid_i ignored (initiator deasserts valid one cycle late); go IDLE.
REQ-020 Latency: request accepted in cycle N SHALL see mem_ready_o in cycle N+LATENCY+1; minimum inter-request spacing LATENCY+3 cycles.
REQ-021 Inputs SHALL be ignored after acceptance until IDLE; latched values govern the transaction.
REQ-022 Valid withdrawn before mem_ready_o SHALL NOT abort; transaction completes and pulses mem_ready_o.
REQ-023 mem_rdata_o SHALL hold its last value outside RESP; write transactions SHALL NOT change mem_rdata_o.
REQ-024 Address >= MEM_DEPTH: read returns all-zero, write dropped (RAM untouched), timing unchanged.
REQ-025 Read after write to same address SHALL return the written data.

Reset
REQ-026 rst_ni low SHALL force state IDLE, mem_ready_o=0, mem_rdata_o=0, err_o=0, counter=0, latched request cleared, asynchronously.
REQ-027 Reset mid-transaction SHALL abandon it with no mem_ready_o pulse; an uncommitted write SHALL NOT reach RAM.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MEM_RESPONDER_ERR_EN defined: err_o=1 in the RESP cycle of any out-of-range transaction, else 0.
REQ-030 Macro MEM_RESPONDER_ERR_EN undefined: err_o tied 0, no comparator logic; REQ-024 data behaviour unchanged.

Verification
REQ-031 Write adr 0x0010 data 0xA5A5_1234, then read 0x0010 (LATENCY=2) -> read's mem_ready_o exactly 3 cycles after acceptance, mem_rdata_o=0xA5A5_1234.
REQ-032 LATENCY=1 and LATENCY=5 back-to-back reads, valid held one cycle past ready -> ready at N+2 / N+6, no second transaction from late-held valid.
REQ-033 Read adr 0x2000 with MEM_DEPTH=4096 -> mem_rdata_o=0, err_o=1 with macro, err_o=0 without; write to 0x2000 leaves 0x0000 unchanged.
REQ-034 rst_ni low in WAIT of write 0xDEAD_BEEF to 0x0020 -> no mem_ready_o, outputs 0, later read 0x0020 returns prior contents.
REQ-035 Change mem_adr_i/mem_wdata_i during WAIT of write to 0x0030 -> RAM[0x0030] gets originally latched data, other addresses unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder with valid/ready handshake.
// Optional address-error flag on err_o is enabled by MEM_RESPONDER_ERR_EN.
module prim_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4096
) (
   input  logic                     clk_i,
   input  logic                     en_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Storage is deliberately not reset so contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) r_mem[addr_i] <= wdata_i;
         else      r_rdata <= r_mem[addr_i];
      end
   end

   assign rdata_o = r_rdata;

endmodule

module mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 4096,
   parameter int LATENCY    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  mem_valid_i,
   output logic                  mem_ready_o,
   input  logic                  mem_we_i,
   input  logic [ADDR_WIDTH-1:0] mem_adr_i,
   input  logic [DATA_WIDTH-1:0] mem_wdata_i,
   output logic [DATA_WIDTH-1:0] mem_rdata_o,
   output logic                  err_o
);

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      GAP
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_cnt;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  w_oor;
   logic                  w_ready;
   logic                  w_ram_en;
   logic                  w_ram_we;
   logic [DATA_WIDTH-1:0] w_ram_q;
   logic [DATA_WIDTH-1:0] w_rd;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (mem_valid_i) w_next = WAIT;
         WAIT:    if (r_cnt == 4'd0) w_next = RESP;
         RESP:    w_next = GAP;
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_ready  = (r_state == RESP);
      w_ram_en = 1'b0;
      w_ram_we = 1'b0;
      if (r_state == WAIT && r_cnt == 4'd0 && !r_we) w_ram_en = 1'b1;
      if (r_state == RESP && r_we && !w_oor) begin
         w_ram_en = 1'b1;
         w_ram_we = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_wdata <= '0;
      end else if (r_state == IDLE && mem_valid_i) begin
         r_cnt   <= 4'(LATENCY - 1);
         r_we    <= mem_we_i;
         r_adr   <= mem_adr_i;
         r_wdata <= mem_wdata_i;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Held copy keeps rdata stable between read responses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   r_rdata <= '0;
      else if (w_ready && !r_we)     r_rdata <= w_rd;
   end

   assign w_oor = ({1'b0, r_adr} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));
   assign w_rd  = w_oor ? '0 : w_ram_q;

   assign mem_ready_o = w_ready;
   assign mem_rdata_o = (w_ready && !r_we) ? w_rd : r_rdata;

`ifdef MEM_RESPONDER_ERR_EN
   assign err_o = w_ready && w_oor;
`else
   assign err_o = 1'b0;
`endif

   prim_ram #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (MEM_DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .en_i    (w_ram_en),
      .we_i    (w_ram_we),
      .addr_i  (r_adr[AW-1:0]),
      .wdata_i (r_wdata),
      .rdata_o (w_ram_q)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances at LATENCY 2, 1 and 5
// share one request stream; each scenario checks only its target instance.
module tb_mem_responder;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        we    = 1'b0;
   logic [15:0] adr   = '0;
   logic [31:0] wdata = '0;

   logic        rdy0, rdy1, rdy2;
   logic        er0, er1, er2;
   logic [31:0] rd0, rd1, rd2;

   int checks = 0;
   int errors = 0;
   bit exp_err;

   always #5 clk = ~clk;

   mem_responder #(.LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid),
      .mem_ready_o(rdy0), .mem_we_i(we), .mem_adr_i(adr),
      .mem_wdata_i(wdata), .mem_rdata_o(rd0), .err_o(er0)
   );

   mem_responder #(.LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid),
      .mem_ready_o(rdy1), .mem_we_i(we), .mem_adr_i(adr),
      .mem_wdata_i(wdata), .mem_rdata_o(rd1), .err_o(er1)
   );

   mem_responder #(.LATENCY(5)) u_l5 (
      .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid),
      .mem_ready_o(rdy2), .mem_we_i(we), .mem_adr_i(adr),
      .mem_wdata_i(wdata), .mem_rdata_o(rd2), .err_o(er2)
   );

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   // lat counts cycles from the accepting cycle (0) to the ready cycle.
   task automatic req(
      input  int          sel,
      input  logic        w,
      input  logic [15:0] a,
      input  logic [31:0] d,
      input  bit          late,
      input  bit          chg,
      input  logic [15:0] a2,
      input  logic [31:0] d2,
      output int          lat,
      output logic [31:0] rd,
      output logic        er
   );
      bit   found;
      logic r;
      found = 0;
      lat   = -1;
      rd    = 'x;
      er    = 1'bx;
      @(posedge clk); #1;
      valid = 1'b1; we = w; adr = a; wdata = d;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         case (sel)
            1:       r = rdy1;
            2:       r = rdy2;
            default: r = rdy0;
         endcase
         if (r) begin
            found = 1;
            lat   = i;
            case (sel)
               1:       begin rd = rd1; er = er1; end
               2:       begin rd = rd2; er = er2; end
               default: begin rd = rd0; er = er0; end
            endcase
         end else if (i == 1 && chg) begin
            adr = a2; wdata = d2;
         end
      end
      @(posedge clk); #1;
      if (late) begin
         @(posedge clk); #1;
      end
      valid = 1'b0;
   endtask

   task automatic no_ready(input int sel, input int n, input string nm);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         case (sel)
            1:       if (rdy1) cnt++;
            2:       if (rdy2) cnt++;
            default: if (rdy0) cnt++;
         endcase
      end
      checks++;
      if (cnt !== 0) begin
         errors++;
         $display("FAIL %s: ready pulses=%0d expected 0", nm, cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++; $display("FAIL rst_ready: got %b exp 0", rdy0);
      end
      checks++;
      if (rd0 !== 32'h0) begin
         errors++; $display("FAIL rst_rdata: got %h exp 0", rd0);
      end
      checks++;
      if (er0 !== 1'b0) begin
         errors++; $display("FAIL rst_err: got %b exp 0", er0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic er;
      idle(12);
      req(0, 1, 16'h0010, 32'hA5A5_1234, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL wr_lat: got %0d exp 3", lat);
      end
      req(0, 0, 16'h0010, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL rd_lat: got %0d exp 3", lat);
      end
      checks++;
      if (rd !== 32'hA5A5_1234) begin
         errors++; $display("FAIL rd_data: got %h exp a5a51234", rd);
      end
      checks++;
      if (er !== 1'b0) begin
         errors++; $display("FAIL rd_err: got %b exp 0", er);
      end
      req(0, 1, 16'h0011, 32'h55AA_55AA, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'hA5A5_1234) begin
         errors++; $display("FAIL wr_hold_rdata: got %h exp a5a51234", rd);
      end
      idle(3);
      checks++;
      if (rd0 !== 32'hA5A5_1234) begin
         errors++; $display("FAIL idle_hold_rdata: got %h exp a5a51234", rd0);
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] rd; logic er;
      idle(12);
      req(0, 1, 16'h0000, 32'h1111_2222, 0, 0, 0, 0, lat, rd, er);
      req(0, 0, 16'h2000, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL oor_lat: got %0d exp 3", lat);
      end
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL oor_rdata: got %h exp 0", rd);
      end
      checks++;
      if (er !== exp_err) begin
         errors++; $display("FAIL oor_rd_err: got %b exp %b", er, exp_err);
      end
      req(0, 1, 16'h2000, 32'hFFFF_FFFF, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (er !== exp_err) begin
         errors++; $display("FAIL oor_wr_err: got %b exp %b", er, exp_err);
      end
      req(0, 0, 16'h0000, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'h1111_2222) begin
         errors++; $display("FAIL oor_alias: got %h exp 11112222", rd);
      end
   endtask

   task automatic test_back_to_back(input int sel, input int exp_lat);
      int lat; logic [31:0] rd; logic er;
      idle(12);
      for (int k = 0; k < 2; k++) begin
         req(sel, 0, 16'h0010, 0, 1, 0, 0, 0, lat, rd, er);
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL b2b_lat sel%0d #%0d: got %0d exp %0d",
                     sel, k, lat, exp_lat);
         end
         checks++;
         if (rd !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL b2b_data sel%0d #%0d: got %h exp a5a51234",
                     sel, k, rd);
         end
         no_ready(sel, 12, "b2b_late_valid");
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er;
      idle(12);
      req(0, 1, 16'h0020, 32'h1234_5678, 0, 0, 0, 0, lat, rd, er);
      req(0, 0, 16'h0020, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'h1234_5678) begin
         errors++; $display("FAIL pre_rst_data: got %h exp 12345678", rd);
      end
      idle(12);
      @(posedge clk); #1;
      valid = 1'b1; we = 1'b1; adr = 16'h0020; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rd0 !== 32'h0 || rdy0 !== 1'b0 || er0 !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_outputs: rdy=%b rdata=%h err=%b exp 0/0/0",
                  rdy0, rd0, er0);
      end
      valid = 1'b0;
      no_ready(0, 3, "mid_rst_no_ready");
      @(posedge clk); #1;
      rst_n = 1'b1;
      no_ready(0, 8, "post_rst_no_ready");
      req(0, 0, 16'h0020, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'h1234_5678) begin
         errors++; $display("FAIL mid_rst_ram: got %h exp 12345678", rd);
      end
      req(0, 0, 16'h0010, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'hA5A5_1234) begin
         errors++; $display("FAIL rst_keeps_ram: got %h exp a5a51234", rd);
      end
   endtask

   task automatic test_latch();
      int lat; logic [31:0] rd; logic er;
      idle(12);
      req(0, 1, 16'h0031, 32'h3131_3131, 0, 0, 0, 0, lat, rd, er);
      req(0, 1, 16'h0030, 32'hCAFE_F00D, 0, 1, 16'h0031, 32'h0BAD_F00D,
          lat, rd, er);
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL latch_lat: got %0d exp 3", lat);
      end
      req(0, 0, 16'h0030, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL latch_data: got %h exp cafef00d", rd);
      end
      req(0, 0, 16'h0031, 0, 0, 0, 0, 0, lat, rd, er);
      checks++;
      if (rd !== 32'h3131_3131) begin
         errors++; $display("FAIL latch_other: got %h exp 31313131", rd);
      end
   endtask

   initial begin
`ifdef MEM_RESPONDER_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      test_reset();
      test_write_read();
      test_back_to_back(1, 2);
      test_back_to_back(2, 6);
      test_out_of_range();
      test_reset_mid();
      test_latch();
      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
